// File: rtl/hilo_div_seq_pkg.sv
// Shared definitions for the HI/LO divide sequencer: FSM encodings, funct codes, hazard latency.
// Pure constants; no logic, no latency, no flow control.
// Imported by the sequencer top and the pipeline hazard unit.
package hilo_div_seq_pkg;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_BUSY = 2'd1;
  localparam div_state_t DIV_DONE = 2'd2;

  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU = 6'h1B;

  localparam int DIV_WIDTH  = 32;
  // Cycles from accept to the HI/LO write strobe; the hazard unit keys off this.
  localparam int DIV_CYCLES = DIV_WIDTH + 1;

endpackage

// File: rtl/hilo_div_seq_if.sv
// Pipeline-to-divider bundle: EX-stage operands and control in, stall and HI/LO result out.
// Wires only; no latency.
// Backpressure is the stall signal driven by the divider.
interface hilo_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic             flush;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             stall;
  logic             result_valid;
  logic [WIDTH-1:0] lo_out;
  logic [WIDTH-1:0] hi_out;

  modport master (
    output start, is_signed, flush, dividend, divisor,
    input  stall, result_valid, lo_out, hi_out
  );

  modport slave (
    input  start, is_signed, flush, dividend, divisor,
    output stall, result_valid, lo_out, hi_out
  );
endinterface

// File: rtl/hilo_div_seq_div_step.sv
// One radix-2 restoring division iteration on a {rem,quo} pair.
// Purely combinational, zero latency.
// No flow control; the caller decides when to register the result.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // One extra bit so the trial subtract can see a borrow even when rem's MSB is set.
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};

  assign rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/hilo_div_seq.sv
// DIV/DIVU sequencer: latches EX operands, iterates a restoring divider, writes HI/LO once.
// Latency WIDTH+1 cycles from accept to result_valid (1 cycle for divide-by-zero).
// Backpressure: stall holds IF/ID/EX while accepting or busy; flush annuls at any point.
module hilo_div_seq
  import hilo_div_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  hilo_div_seq_if.slave div
);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             dvd_neg;
  logic             dvs_neg;
  logic             accept;
  logic             last_step;

  assign dvd_neg   = div.is_signed & div.dividend[WIDTH-1];
  assign dvs_neg   = div.is_signed & div.divisor[WIDTH-1];
  assign dvd_mag   = dvd_neg ? -div.dividend : div.dividend;
  assign dvs_mag   = dvs_neg ? -div.divisor  : div.divisor;

  assign accept    = (state == DIV_IDLE) && div.start && !div.flush;
  assign last_step = (state == DIV_BUSY) && (cnt == CNT_W'(WIDTH - 1));

  // Stall drops in DONE so the instruction retires in the same cycle HI/LO is written.
  assign div.stall        = !rst && (accept || ((state == DIV_BUSY) && !div.flush));
  assign div.result_valid = !rst && (state == DIV_DONE) && !div.flush;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvsr),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DIV_IDLE;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvsr       <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div.lo_out <= '0;
      div.hi_out <= '0;
    end else if (div.flush) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (div.start) begin
            rem   <= '0;
            quo   <= dvd_mag;
            dvsr  <= dvs_mag;
            cnt   <= '0;
            q_neg <= dvd_neg ^ dvs_neg;
            r_neg <= dvd_neg;
            // Divide-by-zero skips iteration and reports the raw dividend as remainder.
            if (div.divisor == '0) begin
              state      <= DIV_DONE;
              div.lo_out <= '1;
              div.hi_out <= div.dividend;
            end else begin
              state <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (last_step) begin
            state      <= DIV_DONE;
            div.lo_out <= q_neg ? -quo_nxt : quo_nxt;
            div.hi_out <= r_neg ? -rem_nxt : rem_nxt;
          end
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_div_seq.sv
// Directed bench for hilo_div_seq: vector table for single divides plus flush/reset/back-to-back sequences.
module tb_hilo_div_seq;

  logic clk;
  logic rst;

  hilo_div_seq_if #(.WIDTH(32)) bus ();

  hilo_div_seq #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .div (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] lo;
    logic [31:0] hi;
    int          cyc;
  } vec_t;

  vec_t vecs[8];
  int   n_pass;
  int   n_total;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          cyc;
    int          rv_cyc;
    logic        stall_ok;
    logic [31:0] got_lo;
    logic [31:0] got_hi;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = v.sgn;
    bus.dividend  = v.dvd;
    bus.divisor   = v.dvs;
    #1;
    stall_ok = (bus.stall === 1'b1);
    rv_cyc   = -1;
    cyc      = 0;
    got_lo   = '0;
    got_hi   = '0;
    while (rv_cyc < 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.result_valid === 1'b1) begin
        rv_cyc = cyc;
        got_lo = bus.lo_out;
        got_hi = bus.hi_out;
        if (bus.stall !== 1'b0) stall_ok = 1'b0;
        bus.start = 1'b0;
      end else if (bus.stall !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    bus.start = 1'b0;
    check($sformatf("v%0d_latency", idx), 32'(rv_cyc), 32'(v.cyc));
    check($sformatf("v%0d_lo", idx), got_lo, v.lo);
    check($sformatf("v%0d_hi", idx), got_hi, v.hi);
    check($sformatf("v%0d_stall_pattern", idx), {31'b0, stall_ok}, 32'd1);
    @(posedge clk); #1;
    check($sformatf("v%0d_single_pulse", idx), {31'b0, bus.result_valid}, 32'd0);
  endtask

  initial begin
    int          pulses;
    int          rv_cyc;
    logic [31:0] got_lo;
    logic [31:0] got_hi;
    logic [31:0] held_lo;

    n_pass  = 0;
    n_total = 0;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        33};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF, 33};
    vecs[2] = '{1'b0, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC,  32'd1,        33};
    vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0,        33};
    vecs[4] = '{1'b0, 32'd5,          32'd0,        32'hFFFFFFFF,  32'd5,        1};
    vecs[5] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1,        33};
    vecs[6] = '{1'b1, 32'hFFFFFFF8,   32'd0,        32'hFFFFFFFF,  32'hFFFFFFF8, 1};
    vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  32'd0,        33};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.flush     = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd3;
    #1;
    check("reset_stall", {31'b0, bus.stall}, 32'd0);
    check("reset_rv", {31'b0, bus.result_valid}, 32'd0);
    check("reset_lo", bus.lo_out, 32'd0);
    check("reset_hi", bus.hi_out, 32'd0);
    bus.start = 1'b0;
    rst       = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Flush with start in IDLE: nothing latched, outputs hold the last result.
    held_lo = bus.lo_out;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.flush     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd50;
    bus.divisor   = 32'd5;
    #1;
    check("idle_flush_stall", {31'b0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.result_valid === 1'b1) pulses++;
    end
    check("idle_flush_no_pulse", 32'(pulses), 32'd0);
    check("idle_flush_lo_held", bus.lo_out, held_lo);

    // Flush mid-divide at cycle 10, new divide at cycle 12.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    for (int c = 1; c <= 10; c++) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    #1;
    check("busy_flush_stall", {31'b0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    #1;
    check("post_flush_stall", {31'b0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd4;
    #1;
    check("restart_stall", {31'b0, bus.stall}, 32'd1);
    pulses = 0;
    rv_cyc = -1;
    got_lo = '0;
    got_hi = '0;
    for (int c = 13; c <= 50; c++) begin
      @(posedge clk); #1;
      if (bus.result_valid === 1'b1) begin
        pulses++;
        if (rv_cyc < 0) begin
          rv_cyc    = c;
          got_lo    = bus.lo_out;
          got_hi    = bus.hi_out;
          bus.start = 1'b0;
        end
      end
    end
    check("flush_restart_latency", 32'(rv_cyc), 32'd45);
    check("flush_restart_lo", got_lo, 32'd2);
    check("flush_restart_hi", got_hi, 32'd1);
    check("flush_restart_pulses", 32'(pulses), 32'd1);

    // Flush arriving in DONE suppresses the write strobe.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd5;
    bus.divisor  = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b1;
    #1;
    check("done_flush_rv", {31'b0, bus.result_valid}, 32'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (bus.result_valid === 1'b1) pulses++;
    end
    check("done_flush_no_pulse", 32'(pulses), 32'd0);

    // Back-to-back with start held across the DONE cycle.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd10;
    bus.divisor   = 32'd3;
    pulses = 0;
    for (int c = 1; c <= 75; c++) begin
      @(posedge clk); #1;
      if (bus.result_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) begin
          check("b2b_first_cycle", 32'(c), 32'd33);
          check("b2b_first_lo", bus.lo_out, 32'd3);
          check("b2b_first_hi", bus.hi_out, 32'd1);
          bus.is_signed = 1'b1;
          bus.dividend  = 32'hFFFFFFF6;
          bus.divisor   = 32'd3;
        end else if (pulses == 2) begin
          check("b2b_second_cycle", 32'(c), 32'd67);
          check("b2b_second_lo", bus.lo_out, 32'hFFFFFFFD);
          check("b2b_second_hi", bus.hi_out, 32'hFFFFFFFF);
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd2);

    // Reset at cycle 15 of an active divide.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    for (int c = 1; c <= 15; c++) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("rst_mid_stall", {31'b0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("rst_mid_lo", bus.lo_out, 32'd0);
    check("rst_mid_hi", bus.hi_out, 32'd0);
    check("rst_mid_rv", {31'b0, bus.result_valid}, 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.result_valid === 1'b1) pulses++;
    end
    check("rst_mid_no_pulse", 32'(pulses), 32'd0);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd0;
    #1;
    check("rst_idle_accepts", {31'b0, bus.stall}, 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("rst_after_dbz_rv", {31'b0, bus.result_valid}, 32'd1);
    check("rst_after_dbz_hi", bus.hi_out, 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
